// File: rtl/matmul_pkg.sv
// Shared definitions for the systolic matmul slice: writeback FSM states,
// matrix-side derivation and element offset helper.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wb_state_e;

    // Width of the n/m dimension and SP target fields.
    localparam int DIM_W = 2;

    function automatic int calc_max_dim(input int bus_w, input int data_w);
        return bus_w / data_w;
    endfunction

    // Row-major position of element (r,c) in a MAX_DIM x MAX_DIM matrix.
    function automatic int elem_offset(input int r, input int c, input int max_dim);
        return r * max_dim + c;
    endfunction

endpackage

// File: rtl/matmul_wb_addr_gen.sv
// Row/col walker for the writeback stage: row-major over the active region,
// flags the last element and forms the SP word address.
module matmul_wb_addr_gen
    import matmul_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int SP_BASE    = 0,
    parameter int MAX_DIM    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_start,
    input  logic                  i_advance,
    input  logic [DIM_W-1:0]      i_n_dim,
    input  logic [DIM_W-1:0]      i_m_dim,
    input  logic [DIM_W-1:0]      i_target,
    output logic [DIM_W-1:0]      o_row,
    output logic [DIM_W-1:0]      o_col,
    output logic                  o_last,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    logic [DIM_W-1:0] r_row;
    logic [DIM_W-1:0] r_col;
    logic             w_col_wrap;

    assign w_col_wrap = (r_col == i_m_dim);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_start) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= r_row + DIM_W'(1);
            end else begin
                r_col <= r_col + DIM_W'(1);
            end
        end
    end

    // Illegal dims still terminate: the counters are the same width as n/m,
    // so (n,m) is always reached.
    assign o_last = w_col_wrap && (r_row == i_n_dim);

    // Wrap-around into ADDR_WIDTH is intentional.
    assign o_addr = ADDR_WIDTH'(SP_BASE
                                + int'(i_target) * MAX_DIM * MAX_DIM
                                + elem_offset(int'(r_row), int'(r_col), MAX_DIM));

    assign o_row = r_row;
    assign o_col = r_col;

endmodule

// File: rtl/matmul_result_writeback.sv
// Writeback stage: captures the C matrix on finish_mul_i, streams the active
// region into SP one word per accepted beat, then 4-phase handshakes back.
//
// state | meaning
// IDLE  | waiting for finish_mul_i; captures result, dims, target and flags
// WRITE | one SP write request per beat, held until mem_ready_i
// DONE  | finish_write_o high until finish_mul_i drops
module matmul_result_writeback
    import matmul_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int BUS_WIDTH  = 16,
    parameter  int ADDR_WIDTH = 8,
    parameter  int SP_BASE    = 0,
    localparam int MAX_DIM    = calc_max_dim(BUS_WIDTH, DATA_WIDTH)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                finish_mul_i,
    input  logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0] c_matrix_i,
    input  logic [MAX_DIM*MAX_DIM-1:0]          flags_i,
    input  logic [DIM_W-1:0]                    n_dim_i,
    input  logic [DIM_W-1:0]                    m_dim_i,
    input  logic [DIM_W-1:0]                    sp_target_i,
    input  logic                                flags_clr_i,
    input  logic                                mem_ready_i,
    output logic                                mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0]               mem_addr_o,
    output logic [BUS_WIDTH-1:0]                mem_wdata_o,
    output logic [MAX_DIM*MAX_DIM-1:0]          flags_o,
    output logic                                finish_write_o,
    output logic                                busy_o
);

    localparam int NUM_ELEM = MAX_DIM * MAX_DIM;

    wb_state_e                     r_state;
    wb_state_e                     w_state_nxt;
    logic [NUM_ELEM*BUS_WIDTH-1:0] r_c_matrix;
    logic [DIM_W-1:0]              r_n_dim;
    logic [DIM_W-1:0]              r_m_dim;
    logic [DIM_W-1:0]              r_target;
    logic [NUM_ELEM-1:0]           r_flags;
    logic [NUM_ELEM-1:0]           w_flag_mask;
    logic                          w_capture;
    logic                          w_accept;
    logic                          w_last;
    logic [DIM_W-1:0]              w_row;
    logic [DIM_W-1:0]              w_col;
    logic [ADDR_WIDTH-1:0]         w_addr;
    logic [BUS_WIDTH-1:0]          w_elem;
    int                            w_elem_idx;
    logic                          w_in_write;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_capture      = 1'b0;
        w_accept       = 1'b0;
        mem_wr_en_o    = 1'b0;
        finish_write_o = 1'b0;
        busy_o         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (finish_mul_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_wr_en_o = 1'b1;
                if (mem_ready_i) begin
                    w_accept = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                finish_write_o = 1'b1;
                // Wait for finish_mul_i to drop so the held level cannot retrigger.
                if (!finish_mul_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_c_matrix <= '0;
            r_n_dim    <= '0;
            r_m_dim    <= '0;
            r_target   <= '0;
        end else if (w_capture) begin
            r_c_matrix <= c_matrix_i;
            r_n_dim    <= n_dim_i;
            r_m_dim    <= m_dim_i;
            r_target   <= sp_target_i;
        end
    end

    // Flag bits are column-major: bit r + c*MAX_DIM belongs to element (r,c).
    always_comb begin
        w_flag_mask = '0;
        for (int r = 0; r < MAX_DIM; r++) begin
            for (int c = 0; c < MAX_DIM; c++) begin
                if (r <= int'(n_dim_i) && c <= int'(m_dim_i)) begin
                    w_flag_mask[r + c * MAX_DIM] = 1'b1;
                end
            end
        end
    end

    // Capture on the same edge as a clear wins: only the new bits survive.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_flags <= '0;
        end else if (w_capture) begin
            r_flags <= (flags_clr_i ? '0 : r_flags) | (flags_i & w_flag_mask);
        end else if (flags_clr_i) begin
            r_flags <= '0;
        end
    end

    matmul_wb_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .SP_BASE    (SP_BASE),
        .MAX_DIM    (MAX_DIM)
    ) u_addr_gen (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_start    (w_capture),
        .i_advance  (w_accept),
        .i_n_dim    (r_n_dim),
        .i_m_dim    (r_m_dim),
        .i_target   (r_target),
        .o_row      (w_row),
        .o_col      (w_col),
        .o_last     (w_last),
        .o_addr     (w_addr)
    );

    assign w_elem_idx = elem_offset(int'(w_row), int'(w_col), MAX_DIM);

    // Out-of-range indices (illegal dims) read as zero.
    always_comb begin
        w_elem = '0;
        for (int k = 0; k < NUM_ELEM; k++) begin
            if (k == w_elem_idx) begin
                w_elem = r_c_matrix[k * BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    assign w_in_write  = (r_state == ST_WRITE);
    assign mem_addr_o  = w_in_write ? w_addr : '0;
    assign mem_wdata_o = w_in_write ? w_elem : '0;
    assign flags_o     = r_flags;

endmodule

// File: tb/tb_matmul_result_writeback.sv
// Bench for matmul_result_writeback: queue-based reference of the expected SP
// write stream and flag register, plus directed jobs with literal expectations.
module tb_matmul_result_writeback;

    localparam int DW  = 8;
    localparam int BW  = 16;
    localparam int AW  = 8;
    localparam int SPB = 0;
    localparam int MD  = 2;
    localparam int NE  = MD * MD;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             finish_mul = 1'b0;
    logic [NE*BW-1:0] c_matrix   = '0;
    logic [NE-1:0]    flags_in   = '0;
    logic [1:0]       n_dim      = '0;
    logic [1:0]       m_dim      = '0;
    logic [1:0]       sp_target  = '0;
    logic             flags_clr  = 1'b0;
    logic             mem_ready  = 1'b0;
    logic             mem_wr_en;
    logic [AW-1:0]    mem_addr;
    logic [BW-1:0]    mem_wdata;
    logic [NE-1:0]    flags_out;
    logic             finish_write;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    matmul_result_writeback #(
        .DATA_WIDTH (DW),
        .BUS_WIDTH  (BW),
        .ADDR_WIDTH (AW),
        .SP_BASE    (SPB)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .finish_mul_i   (finish_mul),
        .c_matrix_i     (c_matrix),
        .flags_i        (flags_in),
        .n_dim_i        (n_dim),
        .m_dim_i        (m_dim),
        .sp_target_i    (sp_target),
        .flags_clr_i    (flags_clr),
        .mem_ready_i    (mem_ready),
        .mem_wr_en_o    (mem_wr_en),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .flags_o        (flags_out),
        .finish_write_o (finish_write),
        .busy_o         (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: outstanding writes of the current job, handshake phase, flags.
    logic [AW-1:0] exp_addr[$];
    logic [BW-1:0] exp_data[$];
    bit            m_done  = 1'b0;
    logic [NE-1:0] m_flags = '0;

    always @(posedge clk or negedge rst_n) begin : model_p
        bit            idle;
        logic [NE-1:0] nf;
        if (!rst_n) begin
            exp_addr.delete();
            exp_data.delete();
            m_done  = 1'b0;
            m_flags = '0;
        end else begin
            idle = (exp_addr.size() == 0) && !m_done;
            if (idle) begin
                if (finish_mul) begin
                    nf = '0;
                    for (int r = 0; r <= int'(n_dim); r++) begin
                        for (int c = 0; c <= int'(m_dim); c++) begin
                            exp_addr.push_back(AW'(SPB + int'(sp_target) * NE + r * MD + c));
                            exp_data.push_back(c_matrix[(r * MD + c) * BW +: BW]);
                            nf[r + c * MD] = flags_in[r + c * MD];
                        end
                    end
                    m_flags = (flags_clr ? '0 : m_flags) | nf;
                end else if (flags_clr) begin
                    m_flags = '0;
                end
            end else begin
                if (flags_clr) m_flags = '0;
                if (exp_addr.size() > 0) begin
                    if (mem_ready) begin
                        void'(exp_addr.pop_front());
                        void'(exp_data.pop_front());
                        if (exp_addr.size() == 0) m_done = 1'b1;
                    end
                end else if (!finish_mul) begin
                    m_done = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("wr_en", mem_wr_en, exp_addr.size() > 0);
        if (exp_addr.size() > 0) begin
            check("addr", mem_addr, exp_addr[0]);
            check("wdata", mem_wdata, exp_data[0]);
        end
        check("finish_write", finish_write, m_done);
        check("busy", busy, (exp_addr.size() > 0) || m_done);
        check("flags", flags_out, m_flags);
    end

    // Accepted writes of the latest job, with the cycle index (1 = cycle after capture).
    int            log_n;
    logic [AW-1:0] log_addr[16];
    logic [BW-1:0] log_data[16];
    int            log_cyc[16];

    task automatic run_job(input logic [1:0] n, input logic [1:0] m, input logic [1:0] tgt,
                           input logic [NE*BW-1:0] cm, input logic [NE-1:0] fl, input bit clr,
                           input int stall_start, input int stall_len, input int hold,
                           output int done_cyc);
        @(negedge clk);
        finish_mul = 1'b1;
        n_dim      = n;
        m_dim      = m;
        sp_target  = tgt;
        c_matrix   = cm;
        flags_in   = fl;
        flags_clr  = clr;
        mem_ready  = 1'b1;
        log_n      = 0;
        done_cyc   = 0;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Inputs must not be resampled after capture.
                c_matrix  = ~cm;
                flags_in  = ~fl;
                flags_clr = 1'b0;
            end
            mem_ready = !(k >= stall_start && k < stall_start + stall_len);
            if (finish_write) begin
                done_cyc = k;
                break;
            end
            if (mem_wr_en && mem_ready && log_n < 16) begin
                log_addr[log_n] = mem_addr;
                log_data[log_n] = mem_wdata;
                log_cyc[log_n]  = k;
                log_n++;
            end
        end
        mem_ready = 1'b1;
        check("done_reached", done_cyc > 0, 1'b1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_finish", finish_write, 1'b1);
            check("hold_no_write", mem_wr_en, 1'b0);
        end
        finish_mul = 1'b0;
        @(negedge clk);
        check("finish_drop", finish_write, 1'b0);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        logic [NE*BW-1:0] cm_a;
        logic [NE*BW-1:0] cm_b;
        cm_a = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        cm_b = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};

        repeat (2) @(negedge clk);
        check("rst_wr_en", mem_wr_en, 1'b0);
        check("rst_addr", mem_addr, 8'h00);
        check("rst_wdata", mem_wdata, 16'h0000);
        check("rst_finish", finish_write, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_flags", flags_out, 4'b0000);
        rst_n = 1'b1;

        // 2x2, target 1, ready tied high, finish held 10 cycles after DONE.
        run_job(2'd1, 2'd1, 2'd1, cm_a, 4'b0000, 1'b0, 0, 0, 10, dc);
        check("t1_done_cyc", dc, 5);
        check("t1_count", log_n, 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", log_addr[i], 4 + i);
            check("t1_data", log_data[i], i + 1);
            check("t1_cyc", log_cyc[i], i + 1);
        end

        // 1x2: only row 0 is written.
        run_job(2'd0, 2'd1, 2'd0, cm_b, 4'b0000, 1'b0, 0, 0, 1, dc);
        check("t2_count", log_n, 2);
        check("t2_addr0", log_addr[0], 8'd0);
        check("t2_addr1", log_addr[1], 8'd1);
        check("t2_data0", log_data[0], 16'hAAAA);
        check("t2_data1", log_data[1], 16'hBBBB);
        check("t2_done_cyc", dc, 3);

        // 2x2 with ready low on cycles 2..4 (second beat).
        run_job(2'd1, 2'd1, 2'd1, cm_a, 4'b0000, 1'b0, 2, 3, 1, dc);
        check("t3_done_cyc", dc, 8);
        check("t3_count", log_n, 4);
        check("t3_cyc1", log_cyc[1], 5);
        for (int i = 0; i < 4; i++) begin
            check("t3_addr", log_addr[i], 4 + i);
            check("t3_data", log_data[i], i + 1);
        end

        // Flags: mask to active region, sticky OR, clear+capture keeps new bits.
        run_job(2'd0, 2'd0, 2'd0, cm_b, 4'b1111, 1'b0, 0, 0, 1, dc);
        check("f1_flags", flags_out, 4'b0001);
        check("f1_count", log_n, 1);
        run_job(2'd1, 2'd0, 2'd3, cm_b, 4'b0010, 1'b0, 0, 0, 1, dc);
        check("f2_flags", flags_out, 4'b0011);
        check("f2_addr0", log_addr[0], 8'd12);
        check("f2_addr1", log_addr[1], 8'd14);
        check("f2_data1", log_data[1], 16'hCCCC);
        run_job(2'd1, 2'd1, 2'd0, cm_b, 4'b1000, 1'b1, 0, 0, 1, dc);
        check("f3_flags", flags_out, 4'b1000);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        check("f4_clear", flags_out, 4'b0000);

        // Reset in the middle of WRITE, after one accepted beat.
        @(negedge clk);
        finish_mul = 1'b1;
        n_dim      = 2'd1;
        m_dim      = 2'd1;
        sp_target  = 2'd2;
        c_matrix   = cm_a;
        flags_in   = 4'b0101;
        mem_ready  = 1'b1;
        @(negedge clk);
        check("r_beat0_addr", mem_addr, 8'd8);
        check("r_flags_set", flags_out, 4'b0101);
        @(negedge clk);
        check("r_beat1_addr", mem_addr, 8'd9);
        #2 rst_n = 1'b0;
        #1;
        check("r_wr_en", mem_wr_en, 1'b0);
        check("r_addr", mem_addr, 8'h00);
        check("r_wdata", mem_wdata, 16'h0000);
        check("r_busy", busy, 1'b0);
        check("r_finish", finish_write, 1'b0);
        check("r_flags", flags_out, 4'b0000);
        finish_mul = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_job(2'd1, 2'd1, 2'd0, cm_a, 4'b0000, 1'b0, 0, 0, 1, dc);
        check("r_restart_count", log_n, 4);
        check("r_restart_addr0", log_addr[0], 8'd0);
        check("r_restart_data0", log_data[0], 16'h0001);
        check("r_restart_done", dc, 5);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul_result_writeback.md
Name: matmul_result_writeback

Overview:
- Downstream stage of the systolic matrix multiplier.
- On the multiplier's finish pulse, it captures the flat C result matrix and the per-PE overflow flags.
- It streams the valid C elements, one BUS_WIDTH word per accepted beat, into the scratchpad (SP) memory.
- It maintains the sticky overflow-flag register and returns finish_write to the multiplier/control through a 4-phase handshake.

Parameters:
- DATA_WIDTH, 8, operand width; only used to derive MAX_DIM.
- BUS_WIDTH, 16, width of a C element and of an SP word.
- ADDR_WIDTH, 8, SP word-address width.
- SP_BASE, 0, SP word address of target 0, element (0,0).
- MAX_DIM, BUS_WIDTH/DATA_WIDTH, localparam, matrix side.

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, reset; asynchronous, active-low.
- finish_mul_i, in, 1, multiplier done; level, held until control drops start.
- c_matrix_i, in, MAX_DIM*MAX_DIM*BUS_WIDTH, flat result. Element (r,c) is at bits [(r*MAX_DIM+c+1)*BUS_WIDTH-1 -: BUS_WIDTH].
- flags_i, in, MAX_DIM*MAX_DIM, overflow flags. Bit r+c*MAX_DIM belongs to element (r,c).
- n_dim_i, in, 2, rows-1 of C.
- m_dim_i, in, 2, cols-1 of C.
- sp_target_i, in, 2, destination SP matrix slot.
- flags_clr_i, in, 1, clears flags_o.
- mem_ready_i, in, 1, SP accepts the current write this cycle.
- mem_wr_en_o, out, 1, write request.
- mem_addr_o, out, ADDR_WIDTH, write word address.
- mem_wdata_o, out, BUS_WIDTH, write data.
- flags_o, out, MAX_DIM*MAX_DIM, sticky overflow flags.
- finish_write_o, out, 1, writeback complete; held high in DONE.
- busy_o, out, 1, high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, element counters 0, capture registers 0.
- Reset asserted mid-transfer abandons the transfer immediately; no further writes are issued.

FSM states:
- IDLE: on a posedge with finish_mul_i=1, capture c_matrix_i, flags_i, n_dim_i, m_dim_i and sp_target_i. Clear row and col to 0, then go to WRITE. Inputs are not sampled again until the next IDLE.
- WRITE:
  - mem_wr_en_o=1.
  - mem_addr_o = SP_BASE + tgt*MAX_DIM*MAX_DIM + row*MAX_DIM + col, truncated to ADDR_WIDTH (wrap-around is permitted).
  - mem_wdata_o = captured element (row,col).
  - Outputs stay stable until mem_ready_i=1 at a posedge. On that edge, advance col; at col==m, set col=0 and row++.
  - The write at (n,m) accepted with ready goes to DONE.
- DONE: mem_wr_en_o=0, finish_write_o=1. When finish_mul_i=0, go to IDLE; finish_write_o drops the same edge.
  - This 4-phase handshake prevents re-triggering on the held finish_mul_i.

Rules:
- Only elements with row<=n and col<=m are written, in row-major order. Elements outside the active region are never written.
- Count = (n+1)*(m+1); the minimum is 1 (1x1) and the maximum is MAX_DIM*MAX_DIM.
- Latency with mem_ready_i tied to 1:
  - First write is visible in the cycle after capture.
  - finish_write_o rises (n+1)*(m+1)+1 cycles after the capture edge.
- Each cycle with mem_ready_i=0 in WRITE stalls exactly one cycle. Address and data do not change while stalled.
- Flags:
  - On the capture edge, flags_o |= captured flags masked to the active region (r<=n, c<=m).
  - flags_clr_i=1 zeroes flags_o. If clear and capture happen on the same edge, the result is the newly masked flags (set wins).
  - flags_o never clears on its own.
- Element values are passed through unmodified; signed interpretation is irrelevant here.
- n_dim_i or m_dim_i greater than MAX_DIM-1 is illegal; the behaviour is unspecified, but the FSM must still reach DONE.

Decomposition:
- Shared package matmul_pkg holds:
  - the state enum (IDLE, WRITE, DONE);
  - the MAX_DIM derivation;
  - an element-offset function (r*MAX_DIM+c), shared with the multiplier and the operand loader.
- One natural sub-module: matmul_wb_addr_gen, containing the row/col counters, the last-element detect and the address computation.
- The element mux and the FSM remain in the top block.

Test Plan:
- 2x2, ready tied 1, target 1, SP_BASE 0, C = {(0,0)=0x0001, (0,1)=0x0002, (1,0)=0x0003, (1,1)=0x0004}. Required: writes addr 4,5,6,7 with data 1,2,3,4 on consecutive cycles, and finish_write_o high 5 cycles after capture.
- 1x2 (n=0, m=1): exactly 2 writes (addr 0, 1). The row-1 elements are never driven.
- Stalls: ready low for 3 cycles on the second beat. Required: addr and data held stable, 4 writes still in order, finish_write_o delayed by 3 cycles.
- Flags: flags_i=0b1111 with n=0, m=0 gives flags_o=0b0001. A second run with bit 1 set and m=0, n=1 gives 0b0011. Clear and capture on the same edge give only the new bits.
- Handshake: hold finish_mul_i high for 10 cycles after DONE. Required: no second transfer; finish_write_o stays 1 and drops on the edge after finish_mul_i falls.
- Reset asserted mid-WRITE (after 1 beat): all outputs 0 immediately, and a new finish_mul_i restarts from element (0,0).
